boot_rom_copier: RTL and testbench

//  Initiator for the boot code ROM port. On START it reads LEN words from the ROM (CSN/A/Q, 1-cycle latency),

---
 rtl/boot_copy_pkg.sv | 18 +
 rtl/boot_rom_copier.sv | 154 +++++++++++++++
 tb/tb_boot_rom_copier.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/boot_copy_pkg.sv
// Shared types and constants for the boot ROM to instruction RAM copier.
package boot_copy_pkg;

  localparam int ROM_AW_DEF    = 10;
  localparam int ROM_DEPTH_DEF = 548;
  localparam int DATA_W_DEF    = 32;

  localparam logic [3:0] RAM_BE_FULL = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_WRITE = 3'd3,
    ST_FIN   = 3'd4
  } state_t;

endpackage

// File: rtl/boot_rom_copier.sv
// Copies len words from the boot ROM (1-cycle read latency) into instruction
// RAM over a REQ/GNT write port, accumulating a mod-2^32 checksum.
//
// Handshake: RAM_REQ rises in WRITE and stays high with RAM_ADDR/RAM_WDATA
// stable until the rising clock edge where RAM_REQ and RAM_GNT are both high;
// that edge is the single transfer. RAM_GNT while RAM_REQ is low has no effect.
module boot_rom_copier
  import boot_copy_pkg::*;
#(
  parameter int ROM_AW    = ROM_AW_DEF,
  parameter int ROM_DEPTH = ROM_DEPTH_DEF,
  parameter int DATA_W    = DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ROM_AW:0]   i_len,
  input  logic [31:0]       i_dst_addr,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_checksum,
  output logic              o_rom_csn,
  output logic [ROM_AW-1:0] o_rom_a,
  input  logic [DATA_W-1:0] i_rom_q,
  output logic              o_ram_req,
  input  logic              i_ram_gnt,
  output logic [31:0]       o_ram_addr,
  output logic              o_ram_we,
  output logic [3:0]        o_ram_be,
  output logic [DATA_W-1:0] o_ram_wdata,
  output state_t            o_dbg_state
);

  localparam int LEN_W = ROM_AW + 1;
  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(ROM_DEPTH);

  state_t r_state;
  state_t w_state_nxt;

  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_idx;
  logic [ROM_AW-1:0] r_rom_a;
  logic [31:0]       r_ram_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_checksum;
  logic              r_busy;
  logic              r_done;

  logic [LEN_W-1:0]  w_len_clamped;
  logic [LEN_W-1:0]  w_idx_inc;
  logic              w_last;
  logic              w_wr_fire;
  logic              w_rom_csn;
  logic              w_ram_req;

  assign w_len_clamped = (i_len > DEPTH_L) ? DEPTH_L : i_len;
  assign w_idx_inc     = r_idx + 1'b1;
  assign w_last        = (w_idx_inc == r_len);
  assign w_wr_fire     = (r_state == ST_WRITE) && i_ram_gnt;

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and port-control decode
  always_comb begin
    w_state_nxt = r_state;
    w_rom_csn   = 1'b1;
    w_ram_req   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) w_state_nxt = (w_len_clamped == '0) ? ST_FIN : ST_FETCH;
      end
      ST_FETCH: begin
        w_rom_csn   = 1'b0;
        w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        w_state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        w_ram_req = 1'b1;
        if (i_ram_gnt) w_state_nxt = w_last ? ST_FIN : ST_FETCH;
      end
      ST_FIN: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Copy datapath: length/address latch, word index, data capture, checksum, status flags
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_len      <= '0;
      r_idx      <= '0;
      r_rom_a    <= '0;
      r_ram_addr <= '0;
      r_wdata    <= '0;
      r_checksum <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= (r_state == ST_FIN);
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_len      <= w_len_clamped;
            r_idx      <= '0;
            r_rom_a    <= '0;
            r_ram_addr <= i_dst_addr;
            r_checksum <= '0;
            r_busy     <= 1'b1;
          end
        end
        ST_LOAD: begin
          r_wdata    <= i_rom_q;
          r_checksum <= r_checksum + i_rom_q;
        end
        ST_WRITE: begin
          if (w_wr_fire) begin
            r_idx      <= w_idx_inc;
            r_ram_addr <= r_ram_addr + 32'd4;
            // ROM_A only moves when another fetch follows, so it never
            // points past the last valid ROM word.
            if (!w_last) r_rom_a <= w_idx_inc[ROM_AW-1:0];
          end
        end
        ST_FIN: begin
          r_busy <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_checksum  = r_checksum;
  assign o_rom_csn   = w_rom_csn;
  assign o_rom_a     = r_rom_a;
  assign o_ram_req   = w_ram_req;
  assign o_ram_we    = w_ram_req;
  assign o_ram_be    = w_ram_req ? RAM_BE_FULL : 4'h0;
  assign o_ram_addr  = r_ram_addr;
  assign o_ram_wdata = r_wdata;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_boot_rom_copier.sv
// Directed bench for boot_rom_copier: ROM model, grant driver, write monitor
// with expected queues, and six directed copy scenarios.
module tb_boot_rom_copier;
  import boot_copy_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUT ----------------
  logic        start;
  logic [10:0] len;
  logic [31:0] dst_addr;
  logic        o_busy, o_done, o_rom_csn, o_ram_req, o_ram_we;
  logic [31:0] o_checksum, o_ram_addr, o_ram_wdata;
  logic [9:0]  o_rom_a;
  logic [3:0]  o_ram_be;
  logic [31:0] rom_q;
  logic        gnt;
  state_t      o_dbg_state;

  boot_rom_copier dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_len       (len),
    .i_dst_addr  (dst_addr),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_checksum  (o_checksum),
    .o_rom_csn   (o_rom_csn),
    .o_rom_a     (o_rom_a),
    .i_rom_q     (rom_q),
    .o_ram_req   (o_ram_req),
    .i_ram_gnt   (gnt),
    .o_ram_addr  (o_ram_addr),
    .o_ram_we    (o_ram_we),
    .o_ram_be    (o_ram_be),
    .o_ram_wdata (o_ram_wdata),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Boot image: word i = 0x1000_0000 + i*0x0001_0001
  function automatic logic [31:0] rom_word(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h0001_0001;
  endfunction

  // ROM model: 1-cycle latency, holds Q while CSN is high
  always @(posedge clk) begin
    if (!o_rom_csn) rom_q <= rom_word(int'(o_rom_a));
  end

  // Grant driver: stalls the first stall_left write cycles
  int stall_left = 0;
  initial begin
    gnt = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_left > 0 && o_ram_req) begin
        gnt = 1'b0;
        stall_left--;
      end else begin
        gnt = 1'b1;
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  int          wr_cnt = 0, done_cnt = 0, csn_cnt = 0, req_cnt = 0;
  int          w0 = 0, c0 = 0, r0 = 0;
  logic [9:0]  last_rom_a = '0, max_rom_a = '0;
  logic [31:0] third_addr = '0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr = '0, prev_data = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (o_ram_req) req_cnt++;
        if (o_done) done_cnt++;
        if (!o_rom_csn) begin
          csn_cnt++;
          last_rom_a = o_rom_a;
          if (o_rom_a > max_rom_a) max_rom_a = o_rom_a;
        end
        if (prev_stall) begin
          check("req_hold", 32'(o_ram_req), 32'd1);
          check("addr_hold", o_ram_addr, prev_addr);
          check("wdata_hold", o_ram_wdata, prev_data);
        end
        if (o_ram_req && gnt) begin
          check("wr_we", 32'(o_ram_we), 32'd1);
          check("wr_be", 32'(o_ram_be), 32'hF);
          if (wr_cnt - w0 == 2) third_addr = o_ram_addr;
          if (exp_addr_q.size() == 0) begin
            check("unexpected_wr", o_ram_addr, 32'hDEAD_BEEF);
          end else begin
            check("wr_addr", o_ram_addr, exp_addr_q.pop_front());
            check("wr_data", o_ram_wdata, exp_data_q.pop_front());
          end
          wr_cnt++;
        end
        prev_stall = o_ram_req && !gnt;
        prev_addr  = o_ram_addr;
        prev_data  = o_ram_wdata;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_start(input int n, input logic [31:0] dst);
    @(posedge clk);
    #1;
    start    = 1'b1;
    len      = 11'(n);
    dst_addr = dst;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(o_busy), 32'd0);
    check({tag, "_done"}, 32'(o_done), 32'd0);
    check({tag, "_csum"}, o_checksum, 32'd0);
    check({tag, "_csn"}, 32'(o_rom_csn), 32'd1);
    check({tag, "_rom_a"}, 32'(o_rom_a), 32'd0);
    check({tag, "_req"}, 32'(o_ram_req), 32'd0);
    check({tag, "_we"}, 32'(o_ram_we), 32'd0);
    check({tag, "_be"}, 32'(o_ram_be), 32'd0);
    check({tag, "_addr"}, o_ram_addr, 32'd0);
    check({tag, "_wdata"}, o_ram_wdata, 32'd0);
    check({tag, "_state"}, 32'(o_dbg_state), 32'(ST_IDLE));
  endtask

  // Runs one copy: n = LEN input, exp_n = clamped word count, exp_lat = START->DONE cycles.
  // extra_at >= 0 re-pulses START (LEN=5, DST=0x900) at that cycle while busy.
  task automatic run_copy(input string tag, input int n, input logic [31:0] dst,
                          input int exp_n, input int exp_lat, input int extra_at);
    logic [31:0] sum;
    int lat;
    exp_addr_q.delete();
    exp_data_q.delete();
    sum = '0;
    for (int i = 0; i < exp_n; i++) begin
      exp_addr_q.push_back(dst + 32'(4 * i));
      exp_data_q.push_back(rom_word(i));
      sum = sum + rom_word(i);
    end
    w0 = wr_cnt;
    c0 = csn_cnt;
    r0 = req_cnt;
    max_rom_a = '0;
    begin : done_wait
      int d0;
      d0 = done_cnt;
      drive_start(n, dst);
      lat = -1;
      for (int k = 1; k < 3000; k++) begin
        @(negedge clk);
        if (k == 1) check({tag, "_busy_on"}, 32'(o_busy), 32'd1);
        if (k == extra_at) begin
          start = 1'b1;
          len = 11'd5;
          dst_addr = 32'h0000_0900;
        end else if (k == extra_at + 1) begin
          start = 1'b0;
        end
        if (o_done) begin
          lat = k;
          break;
        end
      end
      start = 1'b0;
      check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      check({tag, "_checksum"}, o_checksum, sum);
      check({tag, "_busy_off"}, 32'(o_busy), 32'd0);
      repeat (20) @(negedge clk);
      check({tag, "_wr_count"}, 32'(wr_cnt - w0), 32'(exp_n));
      check({tag, "_done_count"}, 32'(done_cnt - d0), 32'd1);
      check({tag, "_exp_left"}, 32'(exp_addr_q.size()), 32'd0);
    end
  endtask

  // ---------------- directed tests ----------------
  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    len      = '0;
    dst_addr = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // T1: four words at 0x0, GNT tied high
    run_copy("t1", 4, 32'h0, 4, 14, -1);
    check("t1_csum_const", o_checksum, 32'h4006_0006);

    // T2: two words, first write stalled 5 cycles
    stall_left = 5;
    run_copy("t2", 2, 32'h0000_1000, 2, 13, -1);

    // T3: zero length, no ROM or RAM traffic
    run_copy("t3", 0, 32'h0000_2000, 0, 2, -1);
    check("t3_csn_cycles", 32'(csn_cnt - c0), 32'd0);
    check("t3_req_cycles", 32'(req_cnt - r0), 32'd0);
    check("t3_csum_zero", o_checksum, 32'd0);

    // T4: clamped length and address wrap
    run_copy("t4", 1023, 32'hFFFF_FFF8, 548, 3 * 548 + 2, -1);
    check("t4_last_rom_a", 32'(last_rom_a), 32'd547);
    check("t4_max_rom_a", 32'(max_rom_a), 32'd547);
    check("t4_third_addr", third_addr, 32'h0);

    // T5: reset during WRITE of word 3 of 8
    begin : t5
      int found;
      int d0;
      exp_addr_q.delete();
      exp_data_q.delete();
      for (int i = 0; i < 8; i++) begin
        exp_addr_q.push_back(32'h100 + 32'(4 * i));
        exp_data_q.push_back(rom_word(i));
      end
      w0 = wr_cnt;
      d0 = done_cnt;
      drive_start(8, 32'h0000_0100);
      found = 0;
      for (int k = 0; k < 100; k++) begin
        @(negedge clk);
        if (o_ram_req && o_ram_addr == 32'h0000_010C) begin
          found = 1;
          break;
        end
      end
      check("t5_reached_word3", 32'(found), 32'd1);
      rst = 1'b1;
      #1;
      check_reset_outputs("t5_abort");
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (30) @(negedge clk);
      check("t5_no_done", 32'(done_cnt - d0), 32'd0);
      run_copy("t5b", 1, 32'h0000_0040, 1, 5, -1);
    end

    // T6: START while busy is ignored
    run_copy("t6", 3, 32'h0000_0200, 3, 11, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
